boreal_cursor_integrator: RTL and testbench
===========================================

BOREAL_CURSOR_INTEGRATOR -- requirements
Module: boreal_cursor_integrator

Interface
REQ-001 clk  in  1  sole clock; all state on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low; deassertion synchronous to clk.
REQ-003 valid_in  in  1  one-cycle strobe; x_in valid; driven by the Kalman state stage valid_out.
REQ-004 x_in  in  24 signed  filtered latent intent (Kalman x_est).
REQ-005 deadband  in  24 unsigned  magnitude below which intent is ignored (MMIO).
REQ-006 gain  in  16 signed Q15  intent-to-velocity gain (MMIO).
REQ-007 pos_max  in  16 unsigned  upper cursor bound (MMIO); lower bound is 0.
REQ-008 recenter  in  1  pulse requesting cursor re-centre.
REQ-009 out_ready  in  1  downstream accepts the update.
REQ-010 out_valid  out  1  cursor update available.
REQ-011 pos  out  16 unsigned  cursor position.
REQ-012 vel  out  16 signed  velocity applied in the last update.
REQ-013 drop_cnt  out  8  saturating count of discarded input samples.
REQ-014 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-015 FSM states: IDLE, SCALE, INTEG, HOLD; only IDLE accepts samples.
REQ-016 IDLE: valid_in=1 and no pending recenter -> capture x_in, go to SCALE.
REQ-017 SCALE: compute e = 0 if |x| <= deadband, else x - deadband (x>0) or x + deadband (x<0); form 40-bit product e*gain, arithmetic shift right 15, saturate to [-32768, 32767] into vel; go to INTEG.
REQ-018 INTEG: pos <= clamp(pos + vel, 0, pos_max), computed at >=18-bit signed width, no wrap-around; go to HOLD with out_valid=1.
REQ-019 Latency: valid_in at cycle N -> out_valid high at cycle N+3.
REQ-020 HOLD: out_valid, pos and vel stable until out_ready=1; on that cycle out_valid drops next edge and FSM returns to IDLE.
REQ-021 out_valid and out_ready both high in HOLD = handshake complete; out_ready ignored outside HOLD.
REQ-022 valid_in while FSM is not IDLE -> sample discarded, drop_cnt += 1, saturating at 255.
REQ-023 recenter in any state sets a pending flag; repeated pulses while pending merge into one.
REQ-024 IDLE with pending flag -> pos <= pos_max >> 1, vel <= 0, flag cleared, no out_valid; a valid_in that same cycle is discarded and counted per REQ-022.
REQ-025 pos_max lowered below current pos: pos unchanged until the next INTEG, which clamps it.
REQ-026 deadband >= |x_in|, or gain = 0 -> vel = 0 and an update is still emitted with pos unchanged.
REQ-027 MMIO inputs sampled in SCALE/INTEG only; changes during HOLD do not alter held outputs.

Reset
REQ-028 rst_n low -> immediately: FSM IDLE, out_valid=0, pos=0, vel=0, drop_cnt=0, busy=0, recenter flag cleared, captured sample cleared.
REQ-029 Reset mid-operation (any state) discards the in-flight sample; no out_valid follows reset release until a new valid_in.

Verification
REQ-030 Reset, then recenter with pos_max=1023 -> pos=511, vel=0, out_valid stays 0.
REQ-031 pos=511, deadband=100, gain=0x4000, x_in=1100, out_ready=1 -> out_valid at N+3, vel=500, pos=1011; x_in=-1100 next -> vel=-500, pos=511.
REQ-032 pos=1011, x_in=1100 same settings -> pos clamps to 1023; x_in=-0x7FFFFF, gain=0x7FFF -> vel=-32768, pos=0.
REQ-033 x_in=50, deadband=100 -> vel=0, pos unchanged, out_valid still asserted.
REQ-034 out_ready=0 for 10 cycles, valid_in pulsed 3 times during HOLD -> outputs stable, drop_cnt=3; out_ready=1 -> out_valid falls, busy falls next cycle.
REQ-035 rst_n asserted while in SCALE -> outputs zero asynchronously; after release, no out_valid without new valid_in.

Source files
------------

// File: rtl/boreal_cursor_integrator.sv
// Cursor integrator: turns the filtered intent sample into a velocity
// (deadband, then gain) and integrates it into a clamped cursor position.
// Each accepted sample produces exactly one held update with a ready/valid
// handshake. Samples that arrive while busy are dropped and counted.
module boreal_cursor_integrator (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic signed [23:0] x_in,
  input  logic        [23:0] deadband,
  input  logic signed [15:0] gain,
  input  logic        [15:0] pos_max,
  input  logic               recenter,
  input  logic               out_ready,
  output logic               out_valid,
  output logic        [15:0] pos,
  output logic signed [15:0] vel,
  output logic        [7:0]  drop_cnt,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_SCALE, S_INTEG, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic signed [23:0] x_q, x_d;
  logic signed [15:0] vel_q, vel_d;
  logic        [15:0] pos_q, pos_d;
  logic        [7:0]  drop_q, drop_d;
  logic               ov_q, ov_d;
  logic               pend_q, pend_d;

  // Scale datapath, evaluated from the captured sample.
  // The widths are sized so that neither the magnitude nor the product can
  // overflow, even for x = -2^23.
  logic signed [25:0] xs, db_s, ax, e;
  logic signed [39:0] e_w, g_w, prod, sh;
  logic signed [15:0] vel_sat;

  // Deadband, gain multiply, shift and saturate.
  always_comb begin
    xs   = {{2{x_q[23]}}, x_q};
    db_s = {2'b00, deadband};
    ax   = (xs < 26'sd0) ? -xs : xs;
    if (ax <= db_s)          e = 26'sd0;
    else if (xs < 26'sd0)    e = xs + db_s;
    else                     e = xs - db_s;
    e_w  = {{14{e[25]}}, e};
    g_w  = {{24{gain[15]}}, gain};
    prod = e_w * g_w;
    sh   = prod >>> 15;
    if (sh > 40'sd32767)       vel_sat = 16'sh7FFF;
    else if (sh < -40'sd32768) vel_sat = 16'sh8000;
    else                       vel_sat = sh[15:0];
  end

  // Integration datapath. The 18-bit signed sum cannot wrap, so clamping to
  // [0, pos_max] also pulls in a position left above a lowered pos_max.
  logic signed [17:0] sum;
  logic        [15:0] pos_clamp;

  // Add velocity to position and clamp to [0, pos_max].
  always_comb begin
    sum = $signed({2'b00, pos_q}) + $signed({{2{vel_q[15]}}, vel_q});
    if (sum < 18'sd0)                          pos_clamp = 16'd0;
    else if (sum > $signed({2'b00, pos_max}))  pos_clamp = pos_max;
    else                                       pos_clamp = sum[15:0];
  end

  // Next-state and register updates. A recenter request is stored and is
  // handled only in IDLE. While a request is pending, IDLE does not accept
  // samples.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    vel_d   = vel_q;
    pos_d   = pos_q;
    ov_d    = ov_q;
    drop_d  = drop_q;
    pend_d  = pend_q | recenter;
    if (valid_in && !(state_q == S_IDLE && !pend_q) && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pos_d  = pos_max >> 1;
          vel_d  = 16'sd0;
          pend_d = 1'b0;
        end else if (valid_in) begin
          x_d     = x_in;
          state_d = S_SCALE;
        end
      end
      S_SCALE: begin
        vel_d   = vel_sat;
        state_d = S_INTEG;
      end
      S_INTEG: begin
        pos_d   = pos_clamp;
        ov_d    = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      vel_q  <= '0;
      pos_q  <= '0;
      drop_q <= '0;
      ov_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      vel_q  <= vel_d;
      pos_q  <= pos_d;
      drop_q <= drop_d;
      ov_q   <= ov_d;
      pend_q <= pend_d;
    end
  end

  assign out_valid = ov_q;
  assign pos       = pos_q;
  assign vel       = vel_q;
  assign drop_cnt  = drop_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_boreal_cursor_integrator.sv
// Directed-vector bench for the cursor integrator. The expected values are
// worked out by hand from the deadband, gain, shift, saturate and clamp rules.
module tb_boreal_cursor_integrator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               valid_in;
  logic signed [23:0] x_in;
  logic        [23:0] deadband;
  logic signed [15:0] gain;
  logic        [15:0] pos_max;
  logic               recenter;
  logic               out_ready;
  logic               out_valid;
  logic        [15:0] pos;
  logic signed [15:0] vel;
  logic        [7:0]  drop_cnt;
  logic               busy;

  int n_vec = 0;
  int n_bad = 0;

  boreal_cursor_integrator dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .x_in(x_in),
    .deadband(deadband), .gain(gain), .pos_max(pos_max),
    .recenter(recenter), .out_ready(out_ready), .out_valid(out_valid),
    .pos(pos), .vel(vel), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One active edge. Inputs are driven and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one sample and check the pipeline timing. Each cycle before the
  // update must show no out_valid. The update appears three edges after the sample.
  task automatic send(input int x, input int exp_vel, input int exp_pos, input string tag);
    x_in = x[23:0];
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk({tag, ".ov_n1"}, int'(out_valid), 0);
    step();
    chk({tag, ".ov_n2"}, int'(out_valid), 0);
    step();
    chk({tag, ".ov_n3"}, int'(out_valid), 1);
    chk({tag, ".vel"}, int'(vel), exp_vel);
    chk({tag, ".pos"}, int'(pos), exp_pos);
  endtask

  // Complete the handshake with out_ready held high.
  task automatic retire(input string tag);
    step();
    chk({tag, ".ov_drop"}, int'(out_valid), 0);
    chk({tag, ".busy_drop"}, int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; x_in = '0; deadband = 24'd100;
    gain = 16'sh4000; pos_max = 16'd1023; recenter = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst.ov", int'(out_valid), 0);
    chk("rst.pos", int'(pos), 0);
    chk("rst.vel", int'(vel), 0);
    chk("rst.drop", int'(drop_cnt), 0);
    chk("rst.busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Recenter: the flag is set on the first edge and serviced on the next.
    // A valid_in in the service cycle is dropped.
    recenter = 1'b1;
    step();
    recenter = 1'b0;
    chk("rc.ov0", int'(out_valid), 0);
    valid_in = 1'b1; x_in = 24'd1100;
    step();
    valid_in = 1'b0;
    chk("rc.pos", int'(pos), 511);
    chk("rc.vel", int'(vel), 0);
    chk("rc.ov", int'(out_valid), 0);
    chk("rc.busy", int'(busy), 0);
    chk("rc.drop", int'(drop_cnt), 1);
    step();
    chk("rc.ov2", int'(out_valid), 0);

    // (1100-100)*0x4000 >>> 15 = 500
    send(1100, 500, 1011, "p1");   retire("p1");
    send(-1100, -500, 511, "n1");  retire("n1");
    send(1100, 500, 1011, "p2");   retire("p2");
    send(1100, 500, 1023, "clhi"); retire("clhi");
    gain = 16'sh7FFF;
    send(-24'sh7FFFFF, -32768, 0, "sat"); retire("sat");
    gain = 16'sh4000;
    send(1100, 500, 500, "p3");    retire("p3");
    send(50, 0, 500, "db");        retire("db");
    send(-100, 0, 500, "dbedge");  retire("dbedge");
    gain = 16'sh0000;
    send(5000, 0, 500, "g0");      retire("g0");
    gain = 16'sh4000;

    // Hold: out_ready is low for 10 cycles and three samples arrive.
    // The MMIO inputs change, but the held outputs must stay the same.
    out_ready = 1'b0;
    send(1100, 500, 1000, "hold");
    for (int i = 0; i < 10; i++) begin
      valid_in = (i == 1 || i == 4 || i == 7);
      if (i == 3) begin gain = 16'sh0000; pos_max = 16'd600; end
      step();
      valid_in = 1'b0;
      chk("hold.ov", int'(out_valid), 1);
      chk("hold.pos", int'(pos), 1000);
      chk("hold.vel", int'(vel), 500);
    end
    chk("hold.drop", int'(drop_cnt), 4);
    out_ready = 1'b1;
    retire("hold");
    chk("pm.keep", int'(pos), 1000);
    gain = 16'sh4000;
    // pos_max lowered to 600: the next update (vel 0) clamps pos to 600.
    send(50, 0, 600, "pmclamp");   retire("pmclamp");

    // Reset while the sample is in SCALE.
    x_in = 24'd1100; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("mid.busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.ov", int'(out_valid), 0);
    chk("mid.pos", int'(pos), 0);
    chk("mid.vel", int'(vel), 0);
    chk("mid.drop", int'(drop_cnt), 0);
    chk("mid.busy0", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post.ov", int'(out_valid), 0);
    end
    chk("post.pos", int'(pos), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
